reg_scoreboard: RTL

Register scoreboard sitting directly upstream of the register file, between decode/issue and `reg_file`. It tracks outstanding writes per architectural register, stalls issue on RAW hazards and on saturated per-register counters, and forwards writeback results into the register file's single write port. Optionally, it bypasses a same-cycle writeback into the issuing instruction to avoid a one-cycle stall.

---
 rtl/reg_scoreboard_if.sv | 36 +++
 rtl/reg_scoreboard.sv | 88 ++++++++
 2 files changed

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue, writeback and register-file port bundle for reg_scoreboard
interface reg_scoreboard_if;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_use_rs1;
  logic        issue_use_rs2;
  logic [4:0]  issue_rd;
  logic        issue_wr_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_write_enable;
  logic [4:0]  rf_addr_rd;
  logic [31:0] rf_data_rd;
  logic        fwd_rs1;
  logic        fwd_rs2;
  logic [31:0] fwd_data;
  logic [5:0]  pending_total;
  logic        wb_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
    output issue_rd, issue_wr_rd, wb_valid, wb_rd, wb_data,
    input  issue_ready, rf_write_enable, rf_addr_rd, rf_data_rd,
    input  fwd_rs1, fwd_rs2, fwd_data, pending_total, wb_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
    input  issue_rd, issue_wr_rd, wb_valid, wb_rd, wb_data,
    output issue_ready, rf_write_enable, rf_addr_rd, rf_data_rd,
    output fwd_rs1, fwd_rs2, fwd_data, pending_total, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write scoreboard in front of reg_file
// Define SCOREBOARD_BYPASS_EN to forward a same-cycle writeback into the issuing instruction.
module reg_scoreboard #(
  parameter int PEND_W = 2
) (
  input logic             clk,
  input logic             reset_n,
  reg_scoreboard_if.slave sb
);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

  logic [PEND_W-1:0] cnt     [0:31];
  logic [PEND_W-1:0] cnt_nxt [0:31];
  logic [5:0]        pending_q;
  logic [5:0]        total_nxt;
  logic              err_q;
  logic              waive1;
  logic              waive2;
  logic              haz1;
  logic              haz2;
  logic              sat;
  logic              ready;
  logic              accept;
  logic              err_set;

`ifdef SCOREBOARD_BYPASS_EN
  // Only a last outstanding write may be bypassed; older writes still in flight keep the stall.
  assign waive1      = sb.wb_valid && sb.wb_rd == sb.issue_rs1 && cnt[sb.issue_rs1] == CNT_ONE;
  assign waive2      = sb.wb_valid && sb.wb_rd == sb.issue_rs2 && cnt[sb.issue_rs2] == CNT_ONE;
  assign sb.fwd_rs1  = sb.issue_use_rs1 && sb.issue_rs1 != 5'd0 && waive1;
  assign sb.fwd_rs2  = sb.issue_use_rs2 && sb.issue_rs2 != 5'd0 && waive2;
  assign sb.fwd_data = sb.wb_data;
`else
  assign waive1      = 1'b0;
  assign waive2      = 1'b0;
  assign sb.fwd_rs1  = 1'b0;
  assign sb.fwd_rs2  = 1'b0;
  assign sb.fwd_data = 32'd0;
`endif

  assign haz1 = sb.issue_use_rs1 && sb.issue_rs1 != 5'd0 && cnt[sb.issue_rs1] != '0 && !waive1;
  assign haz2 = sb.issue_use_rs2 && sb.issue_rs2 != 5'd0 && cnt[sb.issue_rs2] != '0 && !waive2;
  assign sat  = sb.issue_wr_rd && sb.issue_rd != 5'd0 && cnt[sb.issue_rd] == CNT_MAX
                && !(sb.wb_valid && sb.wb_rd == sb.issue_rd);

  assign ready          = !haz1 && !haz2 && !sat;
  assign accept         = sb.issue_valid && ready;
  assign err_set        = sb.wb_valid && sb.wb_rd != 5'd0 && cnt[sb.wb_rd] == '0;
  assign sb.issue_ready = ready;

  assign sb.rf_write_enable = sb.wb_valid && sb.wb_rd != 5'd0;
  assign sb.rf_addr_rd      = sb.wb_rd;
  assign sb.rf_data_rd      = sb.wb_data;
  assign sb.pending_total   = pending_q;
  assign sb.wb_err          = err_q;

  always_comb begin
    logic inc;
    logic dec;
    total_nxt = '0;
    for (int r = 0; r < 32; r++) begin
      inc        = accept && sb.issue_wr_rd && sb.issue_rd == 5'(r);
      dec        = sb.wb_valid && sb.wb_rd == 5'(r) && cnt[r] != '0;
      cnt_nxt[r] = cnt[r];
      // x0 never holds a counter, so it stays pinned at zero
      if (r == 0)
        cnt_nxt[r] = '0;
      else if (inc && !dec)
        cnt_nxt[r] = cnt[r] + CNT_ONE;
      else if (dec && !inc)
        cnt_nxt[r] = cnt[r] - CNT_ONE;
      total_nxt = total_nxt + 6'(cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) cnt[r] <= cnt_nxt[r];
      pending_q <= total_nxt;
      err_q     <= err_q | err_set;
    end
  end
endmodule
